des_ip_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational initial-permutation stage of the expanded DES datapath. It applies the DES initial permutation IP, or its inverse IP⁻¹ (final permutation), per 64-bit lane over a LANES×64-bit block. The permutation mode is selected per beat. The block sits between the block-input buffer and round 1 (forward), or between round 16 and the output buffer (inverse). It has a valid/ready handshake, full throughput, backpressure and a tag carried alongside each beat.

---
 rtl/des_ip_pipe.sv | 126 ++++++++++++
 tb/tb_des_ip_pipe.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/des_ip_pipe.sv
// Elastic pipeline applying the DES initial permutation (or its inverse) per 64-bit lane.
// Lane order is reversed on the way through; the tag rides alongside each beat.
module des_ip_pipe #(
  parameter int LANES  = 2,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  inverse_i,
  input  logic [64*LANES-1:0]   data_in_i,
  input  logic [TAG_W-1:0]      tag_in_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [32*LANES-1:0]   l0_o,
  output logic [32*LANES-1:0]   r0_o,
  output logic [TAG_W-1:0]      tag_out_o,
  output logic [2:0]            occupancy_o
);

  localparam int W = 64 * LANES;

  function automatic logic [2:0] rsel(input logic [2:0] g);
    case (g)
      3'd0:    rsel = 3'd6;
      3'd1:    rsel = 3'd4;
      3'd2:    rsel = 3'd2;
      3'd3:    rsel = 3'd0;
      3'd4:    rsel = 3'd7;
      3'd5:    rsel = 3'd5;
      3'd6:    rsel = 3'd3;
      default: rsel = 3'd1;
    endcase
  endfunction

  // Output position j = {g,p} takes source bit {p, R[g]}; position j lives at bit 63-j = ~j.
  function automatic logic [63:0] perm_lane(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    logic [5:0]  pos;
    logic [5:0]  src;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      pos = 6'(j);
      src = {pos[2:0], rsel(pos[5:3])};
      if (inv) y[src] = x[~pos];
      else     y[~pos] = x[src];
    end
    return y;
  endfunction

  logic [W-1:0]                  perm_d;
  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0]             load;
  logic [STAGES-1:0][W-1:0]      data_q, data_d;
  logic [STAGES-1:0][TAG_W-1:0]  tag_q, tag_d;
  logic                          free;
  logic [2:0]                    occ;

  always_comb begin
    perm_d = '0;
    for (int i = 0; i < LANES; i++) begin
      perm_d[64*(LANES-1-i) +: 64] = perm_lane(data_in_i[64*i +: 64], inverse_i);
    end
  end

  // A stage may load if it, or any stage downstream of it, is empty, or the output drains.
  always_comb begin
    free = out_ready_i;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      free    = free | ~valid_q[k];
      load[k] = free;
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    tag_d   = tag_q;
    if (load[0]) begin
      valid_d[0] = in_valid_i;
      if (in_valid_i) begin
        data_d[0] = perm_d;
        tag_d[0]  = tag_in_i;
      end
    end
    for (int k = 1; k < STAGES; k++) begin
      if (load[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          data_d[k] = data_q[k-1];
          tag_d[k]  = tag_q[k-1];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= '0;
      data_q  <= '0;
      tag_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ = occ + {2'b00, valid_q[k]};
    end
  end

  assign in_ready_o  = load[0];
  assign out_valid_o = valid_q[STAGES-1];
  assign l0_o        = data_q[STAGES-1][W-1:W/2];
  assign r0_o        = data_q[STAGES-1][W/2-1:0];
  assign tag_out_o   = tag_q[STAGES-1];
  assign occupancy_o = occ;

endmodule

// File: tb/tb_des_ip_pipe.sv
// Scoreboard bench for des_ip_pipe: directed vectors, backpressure, reset flush, random round trip.
module tb_des_ip_pipe;
  localparam int LANES  = 2;
  localparam int STAGES = 3;
  localparam int TAG_W  = 4;
  localparam int W      = 64 * LANES;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic             inverse;
  logic [W-1:0]     data_in;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [W/2-1:0]   l0, r0;
  logic [TAG_W-1:0] tag_out;
  logic [2:0]       occupancy;

  des_ip_pipe #(.LANES(LANES), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .reset_i(reset), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inverse_i(inverse), .data_in_i(data_in), .tag_in_i(tag_in),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .l0_o(l0), .r0_o(r0),
    .tag_out_o(tag_out), .occupancy_o(occupancy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // Standard DES IP table: output bit n (1-based, MSB first) takes input bit ip_tab[n-1].
  int ip_tab [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                      62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                      57,49,41,33,25,17, 9,1, 59,51,43,35,27,19,11,3,
                      61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};

  function automatic logic [63:0] ref_lane(input logic [63:0] x, input logic inv);
    logic [63:0] y;
    y = '0;
    for (int j = 0; j < 64; j++) begin
      if (inv) y[64 - ip_tab[j]] = x[63 - j];
      else     y[63 - j] = x[64 - ip_tab[j]];
    end
    return y;
  endfunction

  function automatic logic [W-1:0] ref_block(input logic [W-1:0] x, input logic inv);
    logic [W-1:0] y;
    y = '0;
    for (int i = 0; i < LANES; i++) y[64*(LANES-1-i) +: 64] = ref_lane(x[64*i +: 64], inv);
    return y;
  endfunction

  logic [W+TAG_W-1:0] sb_q[$];
  logic [W-1:0]       cur_exp;
  bit                 rnd_ready = 1'b0;

  always @(negedge clk) begin
    if (!reset && in_valid && in_ready) sb_q.push_back({cur_exp, tag_in});
  end

  logic               prev_stall = 1'b0;
  logic [W-1:0]       prev_d;
  logic [TAG_W-1:0]   prev_tag;
  logic [W+TAG_W-1:0] ent;

  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_data", 128'({l0, r0}), 128'(prev_d));
        check("stall_valid_tag", 128'({out_valid, tag_out}), 128'({1'b1, prev_tag}));
      end
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_beat: got data %h tag %h, required no beat", {l0, r0}, tag_out);
        end else begin
          ent = sb_q.pop_front();
          check("out_data", 128'({l0, r0}), 128'(ent[W+TAG_W-1:TAG_W]));
          check("out_tag", 128'(tag_out), 128'(ent[TAG_W-1:0]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_d     = {l0, r0};
      prev_tag   = tag_out;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [W-1:0] d, input logic inv, input logic [TAG_W-1:0] t,
                      input logic [W-1:0] e);
    int n;
    n = 0;
    data_in = d; inverse = inv; tag_in = t; cur_exp = e; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        checks++;
        $display("FAIL send_timeout: got in_ready=0 for %0d cycles, required 1", n);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic lat_test(input string name, input logic [W-1:0] d, input logic inv,
                          input logic [W-1:0] e);
    send(d, inv, 4'($urandom), e);
    for (int c = 0; c < STAGES; c++) begin
      @(negedge clk);
      if (c < STAGES - 1) check({name, "_early"}, 128'(out_valid), 128'(0));
      else begin
        check({name, "_valid"}, 128'(out_valid), 128'(1));
        check({name, "_data"}, 128'({l0, r0}), 128'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while ((occupancy != 3'd0 || sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_queue"}, 128'(sb_q.size()), 128'(0));
    check({name, "_occ"}, 128'(occupancy), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [W-1:0]     x, f;
  logic [TAG_W-1:0] t;
  logic             inv_b;

  initial begin
    reset = 1'b1; in_valid = 1'b0; inverse = 1'b0; data_in = '0; tag_in = '0;
    out_ready = 1'b0; cur_exp = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_data", 128'({l0, r0}), 128'(0));
    check("rst_tag", 128'(tag_out), 128'(0));
    check("rst_occ", 128'(occupancy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;

    lat_test("fwd_bit0", 128'h1, 1'b0, 128'h0000_0080_0000_0000_0000_0000_0000_0000);
    lat_test("fwd_bit57", 128'h0200_0000_0000_0000, 1'b0, 128'h1_0000_0000_0000_0000);
    lat_test("fwd_bit121", 128'h0200_0000_0000_0000_0000_0000_0000_0000, 1'b0, 128'h1);
    lat_test("inv_bit64", 128'h1_0000_0000_0000_0000, 1'b1, 128'h0200_0000_0000_0000);
    wait_empty("directed_drain");

    // Backpressure: fill the pipe, confirm it blocks, then stream through a full pipe.
    out_ready = 1'b0;
    for (int b = 0; b < STAGES; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      inv_b = 1'($urandom_range(0, 1));
      send(x, inv_b, 4'($urandom), ref_block(x, inv_b));
    end
    @(negedge clk);
    check("bp_full_occ", 128'(occupancy), 128'(STAGES));
    check("bp_full_in_ready", 128'(in_ready), 128'(0));
    check("bp_full_out_valid", 128'(out_valid), 128'(1));
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      data_in = x; inverse = 1'b0; tag_in = 4'($urandom); cur_exp = ref_block(x, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_blocked_in_ready", 128'(in_ready), 128'(0));
      @(posedge clk);
      #1;
    end
    for (int c = 0; c < 6; c++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      inv_b = 1'($urandom_range(0, 1));
      data_in = x; inverse = inv_b; tag_in = 4'($urandom); cur_exp = ref_block(x, inv_b);
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      check("bp_stream_occ", 128'(occupancy), 128'(STAGES));
      check("bp_stream_in_ready", 128'(in_ready), 128'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_empty("bp_drain");

    // Reset with beats in flight and a beat offered during reset.
    out_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(x, 1'b0, 4'($urandom), ref_block(x, 1'b0));
    end
    x = {$urandom, $urandom, $urandom, $urandom};
    data_in = x; inverse = 1'b0; tag_in = 4'hF; cur_exp = ref_block(x, 1'b0);
    in_valid = 1'b1; reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_data", 128'({l0, r0}), 128'(0));
    check("mid_rst_tag", 128'(tag_out), 128'(0));
    check("mid_rst_occ", 128'(occupancy), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(1));
    repeat (STAGES + 2) @(negedge clk);
    check("mid_rst_no_ghost", 128'(occupancy), 128'(0));
    @(posedge clk);
    #1;

    // Random round trip: forward beat then inverse of its expected result, random backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      t = 4'($urandom);
      f = ref_block(x, 1'b0);
      send(x, 1'b0, t, f);
      send(f, 1'b1, t + 4'd1, x);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    wait_empty("rt_drain");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
